memory_responder: RTL and testbench

- Memory-side responder for the MDR/MAR interface: the other end of the Read/Mdata path the MDR consumes.
- Accepts read and write requests from the CPU datapath and stores words in an internal array.
- Returns read data on Mdataout, which feeds the MDR's Mdata input.
- Models a fixed-latency memory: a wait-state counter and a one-cycle Ready handshake, so the control unit must stall until Ready.

---
 rtl/mem_pkg.sv | 14 +
 rtl/memory_responder_if.sv | 32 +++
 rtl/mem_array.sv | 42 ++++
 rtl/memory_responder.sv | 104 ++++++++++
 tb/tb_memory_responder.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder and its users.
//   state_t    : responder FSM state encoding (IDLE/ACCESS/DONE)
//   MEM_DATA_W : default word width, shared with the MDR so both agree
package mem_pkg;

    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/memory_responder_if.sv
// CPU <-> memory request/response bus.
//   Read, Write : level requests, held by the CPU until Ready
//   addr        : word address from MAR
//   MDatain     : write data from the MDR
//   Mdataout    : read data to the MDR Mdata input
//   Ready       : one-cycle completion pulse
//   Busy        : high while a request is in flight
// Modports: master = CPU side, slave = memory side.
interface memory_responder_if
    import mem_pkg::*;
#(
    parameter int DATA_W = MEM_DATA_W,
    parameter int ADDR_W = 9
);
    logic              Read;
    logic              Write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] MDatain;
    logic [DATA_W-1:0] Mdataout;
    logic              Ready;
    logic              Busy;

    modport master (
        output Read, Write, addr, MDatain,
        input  Mdataout, Ready, Busy
    );

    modport slave (
        input  Read, Write, addr, MDatain,
        output Mdataout, Ready, Busy
    );
endinterface

// File: rtl/mem_array.sv
// Word storage for the memory responder.
//   clk   : write clock
//   we    : synchronous write enable
//   addr  : word address for both read and write
//   wdata : write data
//   rdata : combinational read data
// Addresses >= DEPTH read as zero and ignore writes.
module mem_array #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range;
    logic [IDX_W-1:0]  idx;

    // Extra MSB keeps the compare valid when DEPTH == 2**ADDR_W.
    assign in_range = ({1'b0, addr} < DEPTH_L);
    assign idx      = addr[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

    always_comb begin
        rdata = '0;
        if (in_range) begin
            rdata = mem[idx];
        end
    end
endmodule

// File: rtl/memory_responder.sv
// Fixed-latency memory responder for the MDR/MAR path.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : memory_responder_if slave (Read/Write/addr/MDatain in,
//           Mdataout/Ready/Busy out)
// A request accepted in IDLE is latched, waits LATENCY edges in ACCESS,
// then DONE raises Ready for one cycle. Reset abandons any request.
module memory_responder
    import mem_pkg::*;
#(
    parameter int DATA_W  = MEM_DATA_W,
    parameter int ADDR_W  = 9,
    parameter int DEPTH   = 512,
    parameter int LATENCY = 2
) (
    input  logic                clk,
    input  logic                reset,
    memory_responder_if.slave   bus
);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    logic              lat_rd;
    logic              accept;
    logic              load_rd;
    logic              mem_we;
    logic [DATA_W-1:0] rdata;
    logic [DATA_W-1:0] mdataout_q;

    mem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .addr  (lat_addr),
        .wdata (lat_data),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            lat_addr   <= '0;
            lat_data   <= '0;
            lat_rd     <= 1'b0;
            mdataout_q <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                lat_addr <= bus.addr;
                lat_data <= bus.MDatain;
                // Read wins when both requests are high.
                lat_rd   <= bus.Read;
            end
            if (load_rd) begin
                mdataout_q <= rdata;
            end
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        accept  = 1'b0;
        load_rd = 1'b0;
        mem_we  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.Read || bus.Write) begin
                    accept  = 1'b1;
                    cnt_n   = CNT_LOAD;
                    state_n = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt == '0) begin
                    state_n = S_DONE;
                    load_rd = lat_rd;
                    mem_we  = !lat_rd;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    assign bus.Mdataout = mdataout_q;
    assign bus.Busy     = (state == S_ACCESS);
    assign bus.Ready    = (state == S_DONE);
endmodule

// File: tb/tb_memory_responder.sv
// Directed, table-driven bench for memory_responder (LATENCY=2,
// DEPTH=512, ADDR_W=10 so out-of-range addresses are reachable).
module tb_memory_responder;
    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 2;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              chg;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        logic [DATA_W-1:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    memory_responder_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    memory_responder #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // Ready and Busy must never be high together.
    always @(negedge clk) begin
        if (reset) begin
            check("ready_busy_exclusive", 32'(bus.Ready & bus.Busy), 32'd0);
        end
    end

    function automatic vec_t mk(input logic rd, input logic wr, input int a, input int d,
                                input logic chg, input int ca, input int cd, input int exp);
        vec_t v;
        v.rd  = rd;
        v.wr  = wr;
        v.a   = ADDR_W'(a);
        v.d   = DATA_W'(d);
        v.chg = chg;
        v.ca  = ADDR_W'(ca);
        v.cd  = DATA_W'(cd);
        v.exp = DATA_W'(exp);
        return v;
    endfunction

    // One full transaction, started on a negedge while the DUT is IDLE.
    task automatic do_txn(input vec_t v, input string nm);
        int busy_cycles;
        bit got_ready;
        busy_cycles = 0;
        got_ready = 1'b0;
        bus.Read    = v.rd;
        bus.Write   = v.wr;
        bus.addr    = v.a;
        bus.MDatain = v.d;
        @(posedge clk);
        #1;
        check({nm, "_busy_at_accept"}, 32'(bus.Busy), 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.Ready) begin
                got_ready = 1'b1;
                break;
            end
            if (bus.Busy) busy_cycles++;
            if (v.chg && i == 0) begin
                bus.addr    = v.ca;
                bus.MDatain = v.cd;
            end
        end
        check({nm, "_ready_seen"}, 32'(got_ready), 32'd1);
        check({nm, "_busy_cycles"}, 32'(busy_cycles), 32'(LATENCY));
        check({nm, "_mdataout"}, bus.Mdataout, v.exp);
        bus.Read  = 1'b0;
        bus.Write = 1'b0;
        @(negedge clk);
        check({nm, "_ready_pulse_len"}, 32'(bus.Ready), 32'd0);
        check({nm, "_idle_busy"}, 32'(bus.Busy), 32'd0);
        check({nm, "_mdataout_held"}, bus.Mdataout, v.exp);
    endtask

    vec_t vecs[12];

    initial begin
        bus.Read    = 1'b0;
        bus.Write   = 1'b0;
        bus.addr    = '0;
        bus.MDatain = '0;

        vecs[0]  = mk(1'b0, 1'b1,   5,     23, 1'b0, 0,  0,    0); // write 5
        vecs[1]  = mk(1'b0, 1'b1,   6,     66, 1'b0, 0,  0,    0); // write 6
        vecs[2]  = mk(1'b0, 1'b1,   7,     11, 1'b0, 0,  0,    0); // write 7
        vecs[3]  = mk(1'b0, 1'b1,  88,   1234, 1'b0, 0,  0,    0); // write 88
        vecs[4]  = mk(1'b1, 1'b0,   5,      0, 1'b0, 0,  0,   23); // read 5
        vecs[5]  = mk(1'b1, 1'b0,   5,      0, 1'b1, 6, 35,   23); // inputs change in ACCESS
        vecs[6]  = mk(1'b1, 1'b0,   6,      0, 1'b0, 0,  0,   66); // 6 untouched
        vecs[7]  = mk(1'b1, 1'b1,   5,     99, 1'b0, 0,  0,   23); // read wins
        vecs[8]  = mk(1'b1, 1'b0,   5,      0, 1'b0, 0,  0,   23); // no write happened
        vecs[9]  = mk(1'b0, 1'b1, 600, 'hABCD, 1'b0, 0,  0,   23); // OOR write, Mdataout held
        vecs[10] = mk(1'b1, 1'b0, 600,      0, 1'b0, 0,  0,    0); // OOR read
        vecs[11] = mk(1'b1, 1'b0,  88,      0, 1'b0, 0,  0, 1234); // no alias of 600

        // Reset state
        #1;
        check("reset_mdataout", bus.Mdataout, 32'd0);
        check("reset_ready", 32'(bus.Ready), 32'd0);
        check("reset_busy", 32'(bus.Busy), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            do_txn(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset mid-write: asynchronous clear, write abandoned, no Ready.
        bus.Write   = 1'b1;
        bus.addr    = 10'd7;
        bus.MDatain = 32'd77;
        @(posedge clk);
        #1;
        check("rstw_busy_at_accept", 32'(bus.Busy), 32'd1);
        #3;
        reset = 1'b0;
        #1;
        check("rstw_async_mdataout", bus.Mdataout, 32'd0);
        check("rstw_async_busy", 32'(bus.Busy), 32'd0);
        check("rstw_async_ready", 32'(bus.Ready), 32'd0);
        bus.Write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rstw_no_ready", 32'(bus.Ready), 32'd0);
        end
        do_txn(mk(1'b1, 1'b0, 7, 0, 1'b0, 0, 0, 11), "rstw_read7");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end
endmodule
